// File: rtl/median5_column_buffer_if.sv
// Pixel-in / column-out bundle for the 5x5 median column buffer.
// slave = buffer side, master = upstream source and downstream sorter side.
interface median5_column_buffer_if #(
    parameter int DATA_W = 8
);
    logic              done_i;
    logic [DATA_W-1:0] data_i;
    logic              done_o;
    logic [DATA_W-1:0] S1;
    logic [DATA_W-1:0] S2;
    logic [DATA_W-1:0] S3;
    logic [DATA_W-1:0] S4;
    logic [DATA_W-1:0] S5;
    logic [15:0]       col_o;
    logic [15:0]       row_o;
    logic              frame_done_o;

    modport slave (
        input  done_i, data_i,
        output done_o, S1, S2, S3, S4, S5, col_o, row_o, frame_done_o
    );

    modport master (
        output done_i, data_i,
        input  done_o, S1, S2, S3, S4, S5, col_o, row_o, frame_done_o
    );
endinterface

// File: rtl/median5_column_buffer.sv
// Raster pixels -> 5-tap vertical columns via 4 cascaded line buffers; 1-cycle latency, no backpressure.
// MEDIAN5_ZERO_PAD_EN: emit columns for rows 0..3 too, with taps above the frame forced to 0.
module median5_column_buffer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    median5_column_buffer_if.slave io
);
    localparam int          AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

    logic [DATA_W-1:0] lb0_mem [IMG_WIDTH];
    logic [DATA_W-1:0] lb1_mem [IMG_WIDTH];
    logic [DATA_W-1:0] lb2_mem [IMG_WIDTH];
    logic [DATA_W-1:0] lb3_mem [IMG_WIDTH];

    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] rd0, rd1, rd2, rd3;
    logic              accept;

    logic [15:0]       x_q, x_d, y_q, y_d;
    logic [15:0]       col_q, col_d, row_q, row_d;
    logic              done_q, done_d, fdone_q, fdone_d;
    logic [DATA_W-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, s4_q, s4_d, s5_q, s5_d;

    assign accept = io.done_i;
    assign addr   = x_q[AW-1:0];

    // Read-before-write: rdk is row r-1-k at this x until the edge overwrites it.
    assign rd0 = lb0_mem[addr];
    assign rd1 = lb1_mem[addr];
    assign rd2 = lb2_mem[addr];
    assign rd3 = lb3_mem[addr];

    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            lb0_mem[addr] <= io.data_i;
            lb1_mem[addr] <= rd0;
            lb2_mem[addr] <= rd1;
            lb3_mem[addr] <= rd2;
        end
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        row_d   = row_q;
        done_d  = 1'b0;
        fdone_d = 1'b0;
        s1_d    = s1_q;
        s2_d    = s2_q;
        s3_d    = s3_q;
        s4_d    = s4_q;
        s5_d    = s5_q;
        if (accept) begin
            col_d   = x_q;
            row_d   = y_q;
            fdone_d = (x_q == X_LAST) && (y_q == Y_LAST);
            s5_d    = io.data_i;
`ifdef MEDIAN5_ZERO_PAD_EN
            done_d  = 1'b1;
            // Rows above the frame may still hold the previous frame; mask by row count.
            s4_d    = (y_q >= 16'd1) ? rd0 : '0;
            s3_d    = (y_q >= 16'd2) ? rd1 : '0;
            s2_d    = (y_q >= 16'd3) ? rd2 : '0;
            s1_d    = (y_q >= 16'd4) ? rd3 : '0;
`else
            done_d  = (y_q >= 16'd4);
            s4_d    = rd0;
            s3_d    = rd1;
            s2_d    = rd2;
            s1_d    = rd3;
`endif
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? 16'd0 : y_q + 16'd1;
            end else begin
                x_d = x_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
            fdone_q <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            s4_q    <= '0;
            s5_q    <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            row_q   <= row_d;
            done_q  <= done_d;
            fdone_q <= fdone_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            s4_q    <= s4_d;
            s5_q    <= s5_d;
        end
    end

    assign io.done_o       = done_q;
    assign io.frame_done_o = fdone_q;
    assign io.col_o        = col_q;
    assign io.row_o        = row_q;
    assign io.S1           = s1_q;
    assign io.S2           = s2_q;
    assign io.S3           = s3_q;
    assign io.S4           = s4_q;
    assign io.S5           = s5_q;
endmodule

// File: tb/tb_median5_column_buffer.sv
// Directed bench for median5_column_buffer on an 8x6 frame, pixel value = base + 8*y + x.
module tb_median5_column_buffer;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;

`ifdef MEDIAN5_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    median5_column_buffer_if #(.DATA_W(DW)) bus ();

    median5_column_buffer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .DATA_W    (DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int x, input int y, input int base);
        return 8'(base + 8 * y + x);
    endfunction

    // Expected {S1..S5}; taps above row 0 read as 0.
    function automatic logic [39:0] exp_col(input int x, input int y, input int base);
        logic [39:0] c;
        c = '0;
        for (int k = 1; k <= 5; k++) begin
            int yy;
            yy = y - (5 - k);
            c  = {c[31:0], (yy < 0) ? 8'd0 : pix(x, yy, base)};
        end
        return c;
    endfunction

    function automatic logic [39:0] got_col();
        return {bus.S1, bus.S2, bus.S3, bus.S4, bus.S5};
    endfunction

    task automatic cycle(input logic d, input logic [7:0] data);
        bus.done_i = d;
        bus.data_i = data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.done_i = 1'b1;
        bus.data_i = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.done_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_done_o got %b want 0", bus.done_o);
        end
        n_checks++;
        if (bus.frame_done_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done_o);
        end
        n_checks++;
        if (got_col() !== 40'd0) begin
            n_fail++; $display("FAIL reset_taps got %h want 0", got_col());
        end
        n_checks++;
        if ({bus.col_o, bus.row_o} !== 32'd0) begin
            n_fail++; $display("FAIL reset_col_row got %0d,%0d want 0,0", bus.col_o, bus.row_o);
        end
        rst        = 1'b0;
        bus.done_i = 1'b0;
    endtask

    task automatic test_full_frame();
        int   n_done;
        logic exp_done;
        n_done = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                cycle(1'b1, pix(x, y, 0));
                exp_done = PAD || (y >= 4);
                if (bus.done_o === 1'b1) n_done++;
                n_checks++;
                if (bus.done_o !== exp_done) begin
                    n_fail++; $display("FAIL full_done (%0d,%0d) got %b want %b", x, y, bus.done_o, exp_done);
                end
                n_checks++;
                if (bus.frame_done_o !== (x == W - 1 && y == H - 1)) begin
                    n_fail++; $display("FAIL full_frame_done (%0d,%0d) got %b", x, y, bus.frame_done_o);
                end
                if (exp_done) begin
                    n_checks++;
                    if ({bus.col_o, bus.row_o} !== {16'(x), 16'(y)}) begin
                        n_fail++; $display("FAIL full_pos got %0d,%0d want %0d,%0d", bus.col_o, bus.row_o, x, y);
                    end
                    n_checks++;
                    if (got_col() !== exp_col(x, y, 0)) begin
                        n_fail++; $display("FAIL full_col (%0d,%0d) got %h want %h", x, y, got_col(), exp_col(x, y, 0));
                    end
                end
                if (exp_done && x == 3 && y == 4) begin
                    n_checks++;
                    if (got_col() !== {8'd3, 8'd11, 8'd19, 8'd27, 8'd35}) begin
                        n_fail++; $display("FAIL full_spot_3_4 got %h want 030b131b23", got_col());
                    end
                end
                if (exp_done && x == 2 && y == 1) begin
                    n_checks++;
                    if (got_col() !== {8'd0, 8'd0, 8'd0, 8'd2, 8'd10}) begin
                        n_fail++; $display("FAIL full_spot_2_1 got %h want 000000020a", got_col());
                    end
                end
                if (exp_done && x == 5 && y == 5) begin
                    n_checks++;
                    if (got_col() !== {8'd13, 8'd21, 8'd29, 8'd37, 8'd45}) begin
                        n_fail++; $display("FAIL full_spot_5_5 got %h want 0d151d252d", got_col());
                    end
                end
            end
        end
        n_checks++;
        if (n_done != (PAD ? W * H : W * (H - 4))) begin
            n_fail++; $display("FAIL full_count got %0d want %0d", n_done, PAD ? W * H : W * (H - 4));
        end
    endtask

    task automatic test_stall();
        logic exp_done;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                cycle(1'b1, pix(x, y, 0));
                exp_done = PAD || (y >= 4);
                n_checks++;
                if (bus.done_o !== exp_done) begin
                    n_fail++; $display("FAIL stall_done (%0d,%0d) got %b want %b", x, y, bus.done_o, exp_done);
                end
                if (exp_done) begin
                    n_checks++;
                    if (got_col() !== exp_col(x, y, 0) || bus.col_o !== 16'(x) || bus.row_o !== 16'(y)) begin
                        n_fail++; $display("FAIL stall_col (%0d,%0d) got %h @%0d,%0d", x, y, got_col(), bus.col_o, bus.row_o);
                    end
                end
                if (x == 3 && y == 4) begin
                    for (int g = 0; g < 2; g++) begin
                        cycle(1'b0, 8'hFF);
                        n_checks++;
                        if (bus.done_o !== 1'b0 || bus.frame_done_o !== 1'b0) begin
                            n_fail++; $display("FAIL stall_gap_done gap%0d got %b", g, bus.done_o);
                        end
                        n_checks++;
                        if (got_col() !== {8'd3, 8'd11, 8'd19, 8'd27, 8'd35}) begin
                            n_fail++; $display("FAIL stall_gap_hold gap%0d got %h want 030b131b23", g, got_col());
                        end
                        n_checks++;
                        if ({bus.col_o, bus.row_o} !== {16'd3, 16'd4}) begin
                            n_fail++; $display("FAIL stall_gap_pos got %0d,%0d want 3,4", bus.col_o, bus.row_o);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_frame_wrap();
        int   pulses;
        logic seen;
        seen = 1'b0;
        for (int f = 0; f < 2; f++) begin
            pulses = 0;
            for (int y = 0; y < H; y++) begin
                for (int x = 0; x < W; x++) begin
                    cycle(1'b1, pix(x, y, 0));
                    if (bus.frame_done_o === 1'b1) pulses++;
                    n_checks++;
                    if (bus.frame_done_o !== (x == W - 1 && y == H - 1)) begin
                        n_fail++; $display("FAIL wrap_pulse f%0d (%0d,%0d) got %b", f, x, y, bus.frame_done_o);
                    end
                    if (f == 1 && bus.done_o === 1'b1 && !seen) begin
                        seen = 1'b1;
                        n_checks++;
                        if ({bus.col_o, bus.row_o} !== {16'd0, PAD ? 16'd0 : 16'd4}) begin
                            n_fail++; $display("FAIL wrap_first_pos got %0d,%0d", bus.col_o, bus.row_o);
                        end
                        n_checks++;
                        if (bus.S1 !== 8'd0 || bus.S5 !== (PAD ? 8'd0 : 8'd32)) begin
                            n_fail++; $display("FAIL wrap_first_taps got S1=%0d S5=%0d", bus.S1, bus.S5);
                        end
                    end
                end
            end
            n_checks++;
            if (pulses != 1) begin
                n_fail++; $display("FAIL wrap_pulse_count f%0d got %0d want 1", f, pulses);
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL wrap_no_done got none want one");
        end
    endtask

    task automatic test_reset_mid();
        logic exp_done;
        for (int i = 0; i <= 3 * W + 4; i++) cycle(1'b1, pix(i % W, i / W, 0));
        rst = 1'b1;
        cycle(1'b1, 8'h55);
        rst = 1'b0;
        n_checks++;
        if (bus.done_o !== 1'b0 || got_col() !== 40'd0 || {bus.col_o, bus.row_o} !== 32'd0) begin
            n_fail++; $display("FAIL midrst_outputs got done=%b col=%h pos=%0d,%0d", bus.done_o, got_col(), bus.col_o, bus.row_o);
        end
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                cycle(1'b1, pix(x, y, 100));
                exp_done = PAD || (y >= 4);
                n_checks++;
                if (bus.done_o !== exp_done) begin
                    n_fail++; $display("FAIL midrst_done (%0d,%0d) got %b want %b", x, y, bus.done_o, exp_done);
                end
                if (exp_done) begin
                    n_checks++;
                    if ({bus.col_o, bus.row_o} !== {16'(x), 16'(y)}) begin
                        n_fail++; $display("FAIL midrst_pos got %0d,%0d want %0d,%0d", bus.col_o, bus.row_o, x, y);
                    end
                    n_checks++;
                    if (got_col() !== exp_col(x, y, 100)) begin
                        n_fail++; $display("FAIL midrst_col (%0d,%0d) got %h want %h", x, y, got_col(), exp_col(x, y, 100));
                    end
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.done_i = 1'b0;
        bus.data_i = '0;
        test_reset();
        test_full_frame();
        test_stall();
        test_frame_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
